// File: rtl/phy_tx_pkg.sv
// -----------------------------------------------------------------------------
// phy_tx_pkg
// Shared constants for the multi-lane PHY transmitter:
//   - default COM/idle symbol value
//   - scrambler LFSR seed and tap positions plus its step function
//   - bit-order encoding used by the MSB_FIRST parameter
// -----------------------------------------------------------------------------
package phy_tx_pkg;

    // Default idle/COM symbol (zero-extended or truncated to WIDTH by users)
    localparam logic [7:0]  PHY_COM_DEFAULT = 8'hBC;

    // Scrambler LFSR: 16 bits, x^16 + x^5 + x^4 + x^3 + 1 style taps
    localparam logic [15:0] LFSR_SEED  = 16'hFFFF;
    localparam int          LFSR_TAP_A = 15;
    localparam int          LFSR_TAP_B = 4;
    localparam int          LFSR_TAP_C = 3;
    localparam int          LFSR_TAP_D = 2;

    // Serial bit-order encoding
    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // One scrambler step: shift left, feedback into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/phy_tx_lane.sv
// -----------------------------------------------------------------------------
// phy_tx_lane
// One serial lane: symbol shifter, idle flag, lane gating and (optionally)
// an output scrambler.
// Optional feature macro: PHY_TX_SCRAMBLE_EN (per-lane 16-bit LFSR scrambler
// applied to data symbols only; idle symbols are sent in the clear).
//
// Ports:
//   clk_i      bit clock
//   reset_i    synchronous active-high reset
//   enable_i   transmitter enable (low clears the lane on the next edge)
//   load_i     capture strobe from the shared symbol counter
//   lane_en_i  output gate for this lane (shifter keeps running when low)
//   valid_i    symbol valid, used on load edges only
//   data_i     parallel symbol, used on load edges only
//   tx_o       serial bit
//   idle_o     high while the symbol being sent is IDLE
// -----------------------------------------------------------------------------
module phy_tx_lane
    import phy_tx_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE      = WIDTH'(PHY_COM_DEFAULT),
    parameter int               MSB_FIRST = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             lane_en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             tx_o,
    output logic             idle_o
);

    localparam bit MSB_OUT = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic             idle_q;
    logic             idle_d;
    logic             out_bit_s;
    logic             line_bit_s;

    // Shifter and idle flag next state: clear when disabled, capture on load, else shift
    always_comb begin
        sh_d   = sh_q;
        idle_d = idle_q;
        if (!enable_i) begin
            sh_d   = '0;
            idle_d = 1'b0;
        end else if (load_i) begin
            sh_d   = valid_i ? data_i : IDLE;
            idle_d = ~valid_i;
        end else begin
            // Shift toward the output bit, zero-filling behind it
            if (MSB_OUT == ORDER_MSB_FIRST) begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end
            idle_d = idle_q;
        end
    end

    // Shifter and idle flag registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sh_q   <= '0;
            idle_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            idle_q <= idle_d;
        end
    end

    // Select the bit currently on the wire end of the shifter
    always_comb begin
        if (MSB_OUT == ORDER_MSB_FIRST) begin
            out_bit_s = sh_q[WIDTH-1];
        end else begin
            out_bit_s = sh_q[0];
        end
    end

`ifdef PHY_TX_SCRAMBLE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        data_q;
    logic        data_d;

    // LFSR and data-symbol flag next state; the LFSR free-runs while enabled
    always_comb begin
        lfsr_d = lfsr_q;
        data_d = data_q;
        if (!enable_i) begin
            lfsr_d = LFSR_SEED;
            data_d = 1'b0;
        end else if (load_i) begin
            lfsr_d = lfsr_next(lfsr_q);
            data_d = valid_i;
        end else begin
            lfsr_d = lfsr_next(lfsr_q);
            data_d = data_q;
        end
    end

    // LFSR and data-symbol flag registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
            data_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            data_q <= data_d;
        end
    end

    // Only data symbols are scrambled; a cleared lane (data_q=0) stays at 0
    assign line_bit_s = out_bit_s ^ (data_q & lfsr_q[15]);
`else
    assign line_bit_s = out_bit_s;
`endif

    assign tx_o   = lane_en_i & line_bit_s;
    assign idle_o = lane_en_i & idle_q;

endmodule

// File: rtl/phy_tx_lanes.sv
// -----------------------------------------------------------------------------
// phy_tx_lanes
// Multi-lane PHY transmitter. A shared symbol counter produces one load edge
// every WIDTH bit-clock cycles; all lanes capture on that edge and serialise
// their symbol (or IDLE when not valid) back-to-back.
// Optional feature macro: PHY_TX_SCRAMBLE_EN (per-lane data scrambler).
//
// Ports:
//   clk_8f      bit clock
//   reset       synchronous active-high reset
//   enable      transmitter enable
//   lane_en     per-lane output enable
//   valid_data  per-lane symbol valid (sampled on load edges)
//   data_in     lane i symbol at [i*WIDTH +: WIDTH]
//   load        combinational capture-edge marker
//   tx_out      per-lane serial output
//   idle_out    per-lane idle indicator
// -----------------------------------------------------------------------------
module phy_tx_lanes
    import phy_tx_pkg::*;
#(
    parameter int               LANES     = 2,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE      = WIDTH'(PHY_COM_DEFAULT),
    parameter int               MSB_FIRST = 1
) (
    input  logic                   clk_8f,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES-1:0]       valid_data,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   load,
    output logic [LANES-1:0]       tx_out,
    output logic [LANES-1:0]       idle_out
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Symbol counter next state: held at 0 while disabled so the first enabled edge loads
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Symbol counter register
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign load = enable & ~reset & (cnt_q == '0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_tx_lane #(
            .WIDTH     (WIDTH),
            .IDLE      (IDLE),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk_i     (clk_8f),
            .reset_i   (reset),
            .enable_i  (enable),
            .load_i    (load),
            .lane_en_i (lane_en[i]),
            .valid_i   (valid_data[i]),
            .data_i    (data_in[i*WIDTH +: WIDTH]),
            .tx_o      (tx_out[i]),
            .idle_o    (idle_out[i])
        );
    end

endmodule

// File: tb/tb_phy_tx_lanes.sv
module tb_phy_tx_lanes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (2 lanes, 8 bits, MSB first)
    logic        rst0;
    logic        en0;
    logic [1:0]  le0;
    logic [1:0]  vd0;
    logic [15:0] din0;
    logic        load0;
    logic [1:0]  tx0;
    logic [1:0]  idle0;

    // Wide instance (4 lanes, 10 bits, LSB first)
    logic        rst1;
    logic        en1;
    logic [3:0]  le1;
    logic [3:0]  vd1;
    logic [39:0] din1;
    logic        load1;
    logic [3:0]  tx1;
    logic [3:0]  idle1;

    phy_tx_lanes u_dut0 (
        .clk_8f     (clk),
        .reset      (rst0),
        .enable     (en0),
        .lane_en    (le0),
        .valid_data (vd0),
        .data_in    (din0),
        .load       (load0),
        .tx_out     (tx0),
        .idle_out   (idle0)
    );

    phy_tx_lanes #(
        .LANES     (4),
        .WIDTH     (10),
        .IDLE      (10'h0BC),
        .MSB_FIRST (0)
    ) u_dut1 (
        .clk_8f     (clk),
        .reset      (rst1),
        .enable     (en1),
        .lane_en    (le1),
        .valid_data (vd1),
        .data_in    (din1),
        .load       (load1),
        .tx_out     (tx1),
        .idle_out   (idle1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  le;
        logic [1:0]  vd;
        logic [15:0] din;
        logic        exp_load;
        logic [1:0]  exp_tx;
        logic [1:0]  exp_idle;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic e, input logic [1:0] le,
                                input logic [1:0] vd, input logic [15:0] d,
                                input logic el, input logic [1:0] et, input logic [1:0] ei);
        vec_t v;
        v.rst = r; v.en = e; v.le = le; v.vd = vd; v.din = d;
        v.exp_load = el; v.exp_tx = et; v.exp_idle = ei;
        vq.push_back(v);
    endfunction

    task automatic set0(input logic r, input logic e, input logic [1:0] le,
                        input logic [1:0] vd, input logic [15:0] d);
        @(negedge clk);
        rst0 = r; en0 = e; le0 = le; vd0 = vd; din0 = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  a5;
    logic [7:0]  bc;
    logic [7:0]  x3c;
    logic [15:0] b2b;
    logic [9:0]  bc10;
    logic [9:0]  one10;

    initial begin
        a5 = 8'hA5; bc = 8'hBC; x3c = 8'h3C;
        b2b = 16'b0000000110000000;
        bc10 = 10'h0BC; one10 = 10'h001;

        rst0 = 1'b1; en0 = 1'b0; le0 = 2'b00; vd0 = 2'b00; din0 = 16'h0000;
        rst1 = 1'b1; en1 = 1'b0; le1 = 4'h0; vd1 = 4'h0; din1 = 40'h0;

        // Reset held with enable and valid data
        for (int i = 0; i < 3; i++)
            add(1'b1, 1'b1, 2'b11, 2'b11, 16'hA5A5, 1'b0, 2'b00, 2'b00);
        // First symbol: lane0 A5, lane1 idle; non-load edges carry junk inputs
        for (int j = 0; j < 8; j++)
            add(1'b0, 1'b1, 2'b11, (j == 0) ? 2'b01 : 2'b11,
                (j == 0) ? 16'h00A5 : 16'h5A5A, (j == 0),
                {bc[3'(7 - j)], a5[3'(7 - j)]}, 2'b10);
        // Back-to-back 01 then 80 on lane0
        for (int j = 0; j < 16; j++)
            add(1'b0, 1'b1, 2'b11, ((j % 8) == 0) ? 2'b01 : 2'b11,
                (j == 0) ? 16'h0001 : ((j == 8) ? 16'h0080 : 16'hFFFF),
                ((j % 8) == 0), {bc[3'(7 - (j % 8))], b2b[4'(15 - j)]}, 2'b10);
        // Lane 0 gated off, both lanes valid FF
        for (int j = 0; j < 8; j++)
            add(1'b0, 1'b1, 2'b10, 2'b11, 16'hFFFF, (j == 0), 2'b10, 2'b00);

        for (int k = 0; k < vq.size(); k++) begin
            set0(vq[k].rst, vq[k].en, vq[k].le, vq[k].vd, vq[k].din);
            check($sformatf("vec%0d_load", k), {31'd0, load0}, {31'd0, vq[k].exp_load});
            tick();
            check($sformatf("vec%0d_tx", k), {30'd0, tx0}, {30'd0, vq[k].exp_tx});
            check($sformatf("vec%0d_idle", k), {30'd0, idle0}, {30'd0, vq[k].exp_idle});
        end

        // Enable drop after the 3rd bit, then restart with a fresh symbol
        set0(1'b0, 1'b1, 2'b11, 2'b01, 16'h00A5);
        check("drop_load0", {31'd0, load0}, 32'd1);
        tick();
        check("drop_bit1", {30'd0, tx0}, 32'd3);
        set0(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000);
        tick();
        check("drop_bit2", {30'd0, tx0}, 32'd0);
        tick();
        check("drop_bit3", {30'd0, tx0}, 32'd3);
        set0(1'b0, 1'b0, 2'b11, 2'b11, 16'hFFFF);
        check("drop_load_off", {31'd0, load0}, 32'd0);
        tick();
        check("drop_tx_off", {30'd0, tx0}, 32'd0);
        check("drop_idle_off", {30'd0, idle0}, 32'd0);
        tick();
        check("drop_tx_off2", {30'd0, tx0}, 32'd0);
        set0(1'b0, 1'b1, 2'b11, 2'b01, 16'h003C);
        check("restart_load", {31'd0, load0}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("restart_bit%0d", j), {30'd0, tx0},
                  {30'd0, bc[3'(7 - j)], x3c[3'(7 - j)]});
            check($sformatf("restart_idle%0d", j), {30'd0, idle0}, 32'd2);
        end

        // Reset asserted mid-symbol
        set0(1'b0, 1'b1, 2'b11, 2'b01, 16'h00A5);
        tick();
        tick();
        set0(1'b1, 1'b1, 2'b11, 2'b01, 16'h00A5);
        check("midrst_load", {31'd0, load0}, 32'd0);
        tick();
        check("midrst_tx", {30'd0, tx0}, 32'd0);
        check("midrst_idle", {30'd0, idle0}, 32'd0);
        set0(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000);
        check("postrst_load", {31'd0, load0}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("postrst_bit%0d", j), {30'd0, tx0},
                  {30'd0, bc[3'(7 - j)], bc[3'(7 - j)]});
        end
        check("postrst_idle", {30'd0, idle0}, 32'd3);

        // Lane 1 re-enabled mid-symbol shows the remaining bits
        set0(1'b0, 1'b1, 2'b01, 2'b11, 16'hA5A5);
        check("reen_load", {31'd0, load0}, 32'd1);
        for (int j = 0; j < 8; j++) begin
            if (j == 4) set0(1'b0, 1'b1, 2'b11, 2'b11, 16'hA5A5);
            tick();
            check($sformatf("reen_bit%0d", j), {30'd0, tx0},
                  {30'd0, (j >= 4) ? a5[3'(7 - j)] : 1'b0, a5[3'(7 - j)]});
        end

        // Wide instance: lane3 10'h001 valid, others idle, LSB first
        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b1; le1 = 4'hF; vd1 = 4'b1000; din1 = {10'h001, 30'h0};
        #1;
        check("w10_load0", {31'd0, load1}, 32'd1);
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("w10_bit%0d", j), {28'd0, tx1},
                  {28'd0, one10[4'(j)], bc10[4'(j)], bc10[4'(j)], bc10[4'(j)]});
            check($sformatf("w10_idle%0d", j), {28'd0, idle1}, 32'd7);
            check($sformatf("w10_load%0d", j + 1), {31'd0, load1}, {31'd0, (j == 9)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phy_tx_lanes.md
# phy_tx_lanes

Parametrised multi-lane PHY transmitter: successor to the fixed two-lane, 8-bit `phy_tx`. Each lane takes a parallel symbol with a valid flag once per symbol period and serialises it one bit per `clk_8f` cycle. When a lane has no valid data it sends the idle/COM symbol instead. Sits between the byte-striping logic and the serial channel, with one shared symbol counter aligning all lanes.

## Interface
- `LANES`, default 2: number of serial lanes.
- `WIDTH`, default 8: symbol width in bits (≥2).
- `IDLE`, default `'hBC` zero-extended to `WIDTH`: idle/COM symbol.
- `MSB_FIRST`, default 1: 1 = MSB first on the wire, 0 = LSB first.

- `clk_8f`  in  1: bit clock, one serial bit per cycle.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: transmitter enable.
- `lane_en`  in  LANES: per-lane output enable.
- `valid_data`  in  LANES: lane i symbol valid, sampled on load edges only.
- `data_in`  in  LANES*WIDTH: lane i symbol at `[i*WIDTH +: WIDTH]`.
- `load`  out  1: combinational; marks the capture edge.
- `tx_out`  out  LANES: registered serial output.
- `idle_out`  out  LANES: registered; high while the symbol on `tx_out[i]` is IDLE.

## Operation
- Shared counter `cnt`, `$clog2(WIDTH)` bits, counts 0..WIDTH-1 and wraps.
  - Advances on each edge with `enable=1`.
  - Forced to 0 when `enable=0`.
- `load = enable & ~reset & (cnt==0)`.
- Per-lane shift register `sh[i]`:
  - Load edge: `sh <= valid_data[i] ? data_in slice : IDLE`, and `idle_out[i] <= ~valid_data[i]`.
  - Other enabled edges: shift toward the output bit. Left shift when `MSB_FIRST=1`, right shift otherwise, zero-filled.
- `tx_out[i]` is the output bit of `sh[i]` (`[WIDTH-1]` or `[0]`), ANDed with `lane_en[i]`. `idle_out[i]` is also gated by `lane_en[i]`.
- `lane_en[i]=0` silences lane i only. Its shifter keeps running, so re-enabling it mid-symbol shows the remaining bits of the current symbol.
- `enable=0`: shifters and `idle_out` clear on the next edge and `tx_out=0`. The current symbol is abandoned, not resumed.
- `valid_data` and `data_in` are ignored on non-load edges.

## Timing
- Reset values: `cnt=0`, all `sh=0`, `tx_out=0`, `idle_out=0`, `load=0`.
- Reset has priority over `enable`. Asserting reset mid-symbol zeroes all outputs on the next edge.
- Latency: for a symbol captured at load edge k, its first bit is on `tx_out` after edge k and its last bit after edge k+WIDTH-1.
- Next load edge is k+WIDTH, so symbols are back-to-back with no gap bits.
- First load edge is the first edge with `enable=1` after reset deasserts, or after `enable` rises.
- Lanes are bit-aligned: all lanes capture on the same edge.

## Configuration
- `PHY_TX_SCRAMBLE_EN` defined:
  - Per-lane 16-bit LFSR, seeded `16'hFFFF` on reset and whenever `enable=0`.
  - Each enabled edge: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[4]^lfsr[3]^lfsr[2]}`.
  - Data-symbol bits are XORed with `lfsr[15]` at the output. IDLE symbols go out unscrambled, but the LFSR still advances.
- Undefined: no LFSR logic; `tx_out` is the raw shifter bit.

## Structure
- Package `phy_tx_pkg` holds:
  - default COM value `8'hBC`;
  - LFSR seed and tap constants;
  - MSB/LSB-first order encoding.
- Sub-module `phy_tx_lane`: one shifter, `idle_out` flag, lane gating and optional LFSR. Instantiated `LANES` times by a generate loop.
- Top level holds `cnt` and `load`.

## Test plan
- Reset: hold `reset=1` for 3 cycles with `enable=1` and data valid -> `tx_out=0`, `idle_out=0`, `load=0` throughout.
- Default parameters:
  - Stimulus: lane0 `8'hA5` valid, lane1 invalid at the first load.
  - Lane0 response: `tx_out[0]` = 1,0,1,0,0,1,0,1 over the next 8 cycles.
  - Lane1 response: `tx_out[1]` = 1,0,1,1,1,1,0,0 (`8'hBC`) with `idle_out[1]=1` for those 8 cycles.
- Back-to-back: `8'h01` then `8'h80` on lane0 -> 16 contiguous bits 0000000110000000; `load` high every 8th cycle.
- Enable drop:
  - `enable=0` after the 3rd bit -> `tx_out=0` from the next cycle.
  - `enable=1` again -> `load=1` that cycle, and a fresh symbol starts from its first bit.
- `lane_en=2'b10` with both lanes valid `8'hFF` -> `tx_out[0]` stays 0; `tx_out[1]` is eight 1s.
- `WIDTH=10`, `MSB_FIRST=0`, `LANES=4`, lane3 `10'h001` valid -> `tx_out[3]` = 1 then nine 0s; the other lanes send IDLE `10'h0BC` LSB first: 0,0,1,1,1,1,0,1,0,0.
